// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin arbiter/sequencer sharing one register-bank port among NREQ requesters.
// Latency: REQ sampled in IDLE -> GNT + bank drive next cycle -> ACK/RDATA the cycle after (1 access / 3 cycles).
// Backpressure: requesters hold REQ and command until GNT; losers wait; a LOCK holder blocks others until release.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   REQ/LOCK/WE [NREQ]       per-requester request, hold-grant request, write(1)/read(0)
//   ADDR/WDATA               packed per-requester commands, requester i at [i*AW +: AW] / [i*DW +: DW]
//   GNT/ACK [NREQ]           registered one-hot grant / one-cycle completion pulse
//   RDATA                    registered read data, valid with ACK (pre-write value on writes)
//   BANK_WE/ADDR/WDATA       registered bank port; BANK_RDATA is the bank's combinational read data
//   TIMEOUT                  one-cycle pulse on a forced lock release
// Optional: define REG_ARB_LOCK_TIMEOUT_EN to force-release a lock that sits idle for MAX_LOCK
// LOCKED cycles; without it a lock persists indefinitely and TIMEOUT is tied low.
module reg_bank_arbiter #(
   parameter int NREQ     = 4,
   parameter int AW       = 3,
   parameter int DW       = 8,
   parameter int MAX_LOCK = 15
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NREQ-1:0]   REQ,
   input  logic [NREQ-1:0]   LOCK,
   input  logic [NREQ-1:0]   WE,
   input  logic [NREQ*AW-1:0] ADDR,
   input  logic [NREQ*DW-1:0] WDATA,
   output logic [NREQ-1:0]   GNT,
   output logic [NREQ-1:0]   ACK,
   output logic [DW-1:0]     RDATA,
   output logic              BANK_WE,
   output logic [AW-1:0]     BANK_ADDR,
   output logic [DW-1:0]     BANK_WDATA,
   input  logic [DW-1:0]     BANK_RDATA,
   output logic              TIMEOUT
);

   localparam int PW = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || MAX_LOCK < 1) begin : g_param_check
      $error("reg_bank_arbiter: NREQ must be 2..8 and MAX_LOCK >= 1");
   end

   typedef enum logic [1:0] {IDLE, ACCESS, DONE, LOCKED} state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            bank_we_q, bank_we_d;
   logic [AW-1:0]   bank_addr_q, bank_addr_d;
   logic [DW-1:0]   bank_wdata_q, bank_wdata_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   win_q, win_d;

`ifdef REG_ARB_LOCK_TIMEOUT_EN
   localparam int LCW = $clog2(MAX_LOCK + 1);
   logic [LCW-1:0]  cnt_q, cnt_d;
   logic            timeout_q, timeout_d;
`endif

   // Round-robin search: first requester above the last winner, wrapping.
   logic          found;
   logic [PW-1:0] cand;
   always_comb begin
      int idx;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!found && REQ[PW'(idx)]) begin
            found = 1'b1;
            cand  = PW'(idx);
         end
      end
   end

   // In LOCKED only the lock owner may be captured; otherwise the round-robin winner.
   logic [PW-1:0]   sel;
   logic [NREQ-1:0] sel_oh;
   logic            capture;
   logic            release_gnt;

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      ack_d        = '0;
      rdata_d      = rdata_q;
      bank_we_d    = 1'b0;
      bank_addr_d  = bank_addr_q;
      bank_wdata_d = bank_wdata_q;
      ptr_d        = ptr_q;
      win_d        = win_q;
      capture      = 1'b0;
      release_gnt  = 1'b0;
`ifdef REG_ARB_LOCK_TIMEOUT_EN
      cnt_d        = cnt_q;
      timeout_d    = 1'b0;
`endif
      sel          = (state_q == LOCKED) ? win_q : cand;
      sel_oh       = '0;
      sel_oh[sel]  = 1'b1;

      case (state_q)
         IDLE: begin
            if (found) capture = 1'b1;
         end
         ACCESS: begin
            // Bank commits the write at this closing edge; read data is the pre-write value.
            rdata_d = BANK_RDATA;
            ack_d   = gnt_q;
            state_d = DONE;
         end
         DONE: begin
            if (LOCK[win_q]) state_d = LOCKED;
            else             release_gnt = 1'b1;
         end
         LOCKED: begin
            if (REQ[win_q]) begin
               capture = 1'b1;
            end else if (!LOCK[win_q]) begin
               release_gnt = 1'b1;
            end else begin
`ifdef REG_ARB_LOCK_TIMEOUT_EN
               if (cnt_q == LCW'(MAX_LOCK - 1)) begin
                  release_gnt = 1'b1;
                  timeout_d   = 1'b1;
                  cnt_d       = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      if (capture) begin
         win_d        = sel;
         gnt_d        = sel_oh;
         bank_we_d    = WE[sel];
         bank_addr_d  = ADDR[sel*AW +: AW];
         bank_wdata_d = WDATA[sel*DW +: DW];
         state_d      = ACCESS;
`ifdef REG_ARB_LOCK_TIMEOUT_EN
         cnt_d        = '0;
`endif
      end

      // Releasing makes the last winner lowest priority for the next search.
      if (release_gnt) begin
         gnt_d   = '0;
         ptr_d   = win_q;
         state_d = IDLE;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         gnt_q        <= '0;
         ack_q        <= '0;
         rdata_q      <= '0;
         bank_we_q    <= 1'b0;
         bank_addr_q  <= '0;
         bank_wdata_q <= '0;
         ptr_q        <= PW'(NREQ - 1);
         win_q        <= '0;
`ifdef REG_ARB_LOCK_TIMEOUT_EN
         cnt_q        <= '0;
         timeout_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         ack_q        <= ack_d;
         rdata_q      <= rdata_d;
         bank_we_q    <= bank_we_d;
         bank_addr_q  <= bank_addr_d;
         bank_wdata_q <= bank_wdata_d;
         ptr_q        <= ptr_d;
         win_q        <= win_d;
`ifdef REG_ARB_LOCK_TIMEOUT_EN
         cnt_q        <= cnt_d;
         timeout_q    <= timeout_d;
`endif
      end
   end

   assign GNT        = gnt_q;
   assign ACK        = ack_q;
   assign RDATA      = rdata_q;
   assign BANK_WE    = bank_we_q;
   assign BANK_ADDR  = bank_addr_q;
   assign BANK_WDATA = bank_wdata_q;
`ifdef REG_ARB_LOCK_TIMEOUT_EN
   assign TIMEOUT    = timeout_q;
`else
   assign TIMEOUT    = 1'b0;
`endif

endmodule
